bc_msg_arbiter: RTL and testbench
=================================

Name: bc_msg_arbiter

Overview:
- Collects broadcast messages (bc_msg_out / valid / ready) from CORE_COUNT riscv_block instances and merges them into one broadcast stream.
- Selects one pending message per cycle using round-robin arbitration.
- Drives the shared bc_msg_in / bc_msg_in_valid that fans out to every core's memory system.
- Sits directly downstream of each core's broadcast output and upstream of all cores' broadcast inputs; the broadcast side has no backpressure.

Parameters:
- CORE_COUNT, 16, number of cores served; must be ≥2.
- CORE_ID_WIDTH, 4, width of core index; must satisfy 2**CORE_ID_WIDTH ≥ CORE_COUNT.
- MSG_WIDTH, 46, message width: {addr, strb[3:0], data[31:0]}; passed through unmodified.

Ports:
- sys_clk  in  1  single clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- core_msg  in  CORE_COUNT*MSG_WIDTH  per-core message; core i occupies bits [i*MSG_WIDTH +: MSG_WIDTH].
- core_msg_valid  in  CORE_COUNT  per-core valid.
- core_msg_ready  out  CORE_COUNT  per-core ready, driven directly from a flop.
- bc_msg  out  MSG_WIDTH  broadcast message to all cores.
- bc_msg_valid  out  1  one-cycle pulse per broadcast message.

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is asynchronous, active-low, on sys_rst_n. All flops clear immediately when sys_rst_n goes low.
- Reset values:
  - core_msg_ready = 0.
  - bc_msg = 0.
  - bc_msg_valid = 0.
  - hold_valid = 0.
  - rr_ptr = CORE_COUNT-1, so core 0 has first priority.
- Per-core holding register (hold_valid[i], hold_data[i]):
  - Accept when core_msg_valid[i] & core_msg_ready[i] at a clock edge.
  - A granted entry clears hold_valid[i] at the edge of its grant.
  - core_msg_ready[i] is registered: next value = ~(next hold_valid[i]).
  - Ready therefore rises the cycle after reset release and the cycle after a grant.
  - Per-core throughput: 1 message per 2 cycles. Aggregate throughput: 1 message per cycle.
- Arbitration (combinational, over hold_valid):
  - Grant the first set index scanning rr_ptr+1, rr_ptr+2, … modulo CORE_COUNT.
  - On a grant, rr_ptr ← granted index. With no request, rr_ptr holds.
- Output register, each cycle:
  - bc_msg_valid ← |hold_valid.
  - bc_msg ← hold_data[grant] when a grant occurs; otherwise bc_msg holds its last value.
- Latency:
  - Message accepted at edge t is visible at the output at edge t+2 when uncontended.
  - Under contention, a message waits at most CORE_COUNT-1 extra cycles.
- Boundary conditions:
  - Simultaneous accept and grant on the same core cannot occur, because ready=0 while hold_valid=1.
  - All cores pending: strict rotation, no starvation.
  - rr_ptr = CORE_COUNT-1 wraps to index 0.
  - Reset asserted mid-operation: pending messages are dropped and bc_msg_valid falls immediately. No partial message is emitted after reset release.
  - An input valid held high while ready=0 is ignored; no data is captured.

Optional Feature:
- Macro: BC_MSG_ARB_STATS_EN.
- Defined: adds output ports bc_msg_count [31:0] and bc_msg_conflict_count [31:0].
  - bc_msg_count increments on each bc_msg_valid pulse.
  - bc_msg_conflict_count increments each cycle in which ≥2 hold_valid bits are set.
  - Both counters reset to 0 and wrap modulo 2^32.
- Not defined: the ports and counters are absent; functional behaviour is identical.

Test Plan:
- Single message: core 3 sends 0x…ABCD with valid at edge 10.
  - core_msg_ready[3]=0 at cycle 11.
  - bc_msg_valid=1 with bc_msg=0x…ABCD at cycle 12, valid=0 at cycle 13.
  - ready[3]=1 from cycle 12.
- Contention: cores 1, 5 and 9 present messages at the same edge after reset.
  - Broadcasts appear in order 1, 5, 9 on three consecutive cycles.
  - rr_ptr ends at 9.
- Fairness: all 16 cores hold valid continuously for 64 cycles.
  - Each core is granted exactly 4 times in strict rotation; the gap between grants of the same core is ≤16 cycles.
- Streaming from one core: core 0 keeps valid high for 20 cycles.
  - Exactly 10 messages are accepted and broadcast, alternating valid 1/0 with ready toggling.
- Reset mid-operation: with 4 messages pending, sys_rst_n goes low between edges.
  - All ready and bc_msg_valid outputs drop immediately.
  - After release, no stale broadcast occurs; ready=1 on the first edge.
  - A new core 2 message is broadcast with value intact.
- Stats (macro defined): 3-core contention burst gives bc_msg_count=3 and bc_msg_conflict_count=2.
  - Preload bc_msg_count to 0xFFFFFFFF via 2^32 forcing; the next message wraps it to 0.

Source files
------------

// File: rtl/bc_msg_arbiter.sv
// ============================================================================
// Module   : bc_msg_arbiter
// Summary  : Round-robin merge of per-core broadcast messages into a single
//            broadcast stream. Each core has a one-entry holding register.
//            Optional statistics counters are built when BC_MSG_ARB_STATS_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bc_msg_arbiter #(
    parameter int CORE_COUNT    = 16,
    parameter int CORE_ID_WIDTH = 4,
    parameter int MSG_WIDTH     = 46
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst_n,
    input  logic [CORE_COUNT*MSG_WIDTH-1:0] core_msg,
    input  logic [CORE_COUNT-1:0]           core_msg_valid,
    output logic [CORE_COUNT-1:0]           core_msg_ready,
    output logic [MSG_WIDTH-1:0]            bc_msg,
    output logic                            bc_msg_valid
`ifdef BC_MSG_ARB_STATS_EN
    ,
    output logic [31:0]                     bc_msg_count,
    output logic [31:0]                     bc_msg_conflict_count
`endif
);

    localparam logic [CORE_ID_WIDTH-1:0] c_RR_RESET = CORE_ID_WIDTH'(CORE_COUNT - 1);
    localparam logic [CORE_COUNT-1:0]    c_ONE      = {{(CORE_COUNT-1){1'b0}}, 1'b1};

    logic [CORE_COUNT-1:0]    r_hold_valid;
    logic [MSG_WIDTH-1:0]     r_hold_data [CORE_COUNT];
    logic [CORE_COUNT-1:0]    r_ready;
    logic [CORE_ID_WIDTH-1:0] r_rr_ptr;
    logic [MSG_WIDTH-1:0]     r_bc_msg;
    logic                     r_bc_msg_valid;

    logic [CORE_COUNT-1:0]    w_accept;
    logic                     w_grant_vld;
    logic [CORE_ID_WIDTH-1:0] w_grant_idx;
    logic [CORE_COUNT-1:0]    w_grant_oh;
    logic [CORE_COUNT-1:0]    w_hold_nxt;

    assign w_accept = core_msg_valid & r_ready;

    // Scan from the highest offset down so the nearest request after rr_ptr wins.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int k = CORE_COUNT; k >= 1; k--) begin
            int idx;
            idx = (int'(r_rr_ptr) + k) % CORE_COUNT;
            if (r_hold_valid[idx]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = CORE_ID_WIDTH'(idx);
            end
        end
    end

    assign w_grant_oh = w_grant_vld ? (c_ONE << w_grant_idx) : '0;
    assign w_hold_nxt = (r_hold_valid & ~w_grant_oh) | w_accept;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_hold_valid   <= '0;
            r_ready        <= '0;
            r_rr_ptr       <= c_RR_RESET;
            r_bc_msg       <= '0;
            r_bc_msg_valid <= 1'b0;
        end else begin
            r_hold_valid   <= w_hold_nxt;
            r_ready        <= ~w_hold_nxt;
            r_bc_msg_valid <= |r_hold_valid;
            if (w_grant_vld) begin
                r_rr_ptr <= w_grant_idx;
                r_bc_msg <= r_hold_data[w_grant_idx];
            end
        end
    end

    // Payload storage needs no reset: it is only observed behind hold_valid.
    always_ff @(posedge sys_clk) begin
        for (int i = 0; i < CORE_COUNT; i++) begin
            if (w_accept[i]) begin
                r_hold_data[i] <= core_msg[i*MSG_WIDTH +: MSG_WIDTH];
            end
        end
    end

    assign core_msg_ready = r_ready;
    assign bc_msg         = r_bc_msg;
    assign bc_msg_valid   = r_bc_msg_valid;

`ifdef BC_MSG_ARB_STATS_EN
    logic [31:0] r_bc_msg_count;
    logic [31:0] r_bc_msg_conflict_count;
    logic        w_multi_pending;

    assign w_multi_pending = |(r_hold_valid & (r_hold_valid - c_ONE));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_bc_msg_count          <= '0;
            r_bc_msg_conflict_count <= '0;
        end else begin
            if (r_bc_msg_valid) begin
                r_bc_msg_count <= r_bc_msg_count + 32'd1;
            end
            if (w_multi_pending) begin
                r_bc_msg_conflict_count <= r_bc_msg_conflict_count + 32'd1;
            end
        end
    end

    assign bc_msg_count          = r_bc_msg_count;
    assign bc_msg_conflict_count = r_bc_msg_conflict_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bc_msg_arbiter.sv
// ============================================================================
// Module   : tb_bc_msg_arbiter
// Summary  : Directed, table-driven self-checking bench for bc_msg_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bc_msg_arbiter;

    localparam int c_N  = 16;
    localparam int c_IW = 4;
    localparam int c_MW = 46;

    logic                  sys_clk;
    logic                  sys_rst_n;
    logic [c_N*c_MW-1:0]   core_msg;
    logic [c_N-1:0]        core_msg_valid;
    logic [c_N-1:0]        core_msg_ready;
    logic [c_MW-1:0]       bc_msg;
    logic                  bc_msg_valid;
`ifdef BC_MSG_ARB_STATS_EN
    logic [31:0]           bc_msg_count;
    logic [31:0]           bc_msg_conflict_count;
`endif

    logic [c_N-1:0]        alt_mask;
    int                    n_tests;
    int                    n_fail;

    bc_msg_arbiter #(
        .CORE_COUNT    (c_N),
        .CORE_ID_WIDTH (c_IW),
        .MSG_WIDTH     (c_MW)
    ) dut (
        .sys_clk               (sys_clk),
        .sys_rst_n             (sys_rst_n),
        .core_msg              (core_msg),
        .core_msg_valid        (core_msg_valid),
        .core_msg_ready        (core_msg_ready),
        .bc_msg                (bc_msg),
        .bc_msg_valid          (bc_msg_valid)
`ifdef BC_MSG_ARB_STATS_EN
        ,
        .bc_msg_count          (bc_msg_count),
        .bc_msg_conflict_count (bc_msg_conflict_count)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [c_MW-1:0] msg_of(input int i);
        return 46'h2BC_0000_ABCD ^ (c_MW'(i) << 20);
    endfunction

    function automatic logic [c_MW-1:0] alt_of(input int i);
        return msg_of(i) ^ 46'h3FFF_0000_0000;
    endfunction

    function automatic int src_of(input logic [c_MW-1:0] m);
        int s;
        s = -1;
        for (int i = 0; i < c_N; i++) begin
            if (msg_of(i) == m) s = i;
        end
        return s;
    endfunction

    always_comb begin
        core_msg = '0;
        for (int i = 0; i < c_N; i++) begin
            core_msg[i*c_MW +: c_MW] = alt_mask[i] ? alt_of(i) : msg_of(i);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    typedef struct {
        logic [c_N-1:0]  vin;
        logic [c_N-1:0]  alt;
        logic [c_N-1:0]  exp_rdy;
        logic            exp_bv;
        logic [c_MW-1:0] exp_bm;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, cyc, exp_src, rot_err, first_cyc, last_cyc, src;
        int cnt [c_N];
        int acc, pat_err, stale;

        n_tests = 0;
        n_fail  = 0;

        // Contention from reset (order 1,5,9), then a lone core-3 message
        // with a blocked-valid data change on the cycle ready is low.
        tbl[0] = '{16'h0222, 16'h0000, 16'hFDDD, 1'b0, '0};
        tbl[1] = '{16'h0000, 16'h0000, 16'hFDDF, 1'b1, msg_of(1)};
        tbl[2] = '{16'h0000, 16'h0000, 16'hFDFF, 1'b1, msg_of(5)};
        tbl[3] = '{16'h0000, 16'h0000, 16'hFFFF, 1'b1, msg_of(9)};
        tbl[4] = '{16'h0000, 16'h0000, 16'hFFFF, 1'b0, msg_of(9)};
        tbl[5] = '{16'h0008, 16'h0000, 16'hFFF7, 1'b0, msg_of(9)};
        tbl[6] = '{16'h0008, 16'h0008, 16'hFFFF, 1'b1, msg_of(3)};
        tbl[7] = '{16'h0000, 16'h0000, 16'hFFFF, 1'b0, msg_of(3)};

        alt_mask       = '0;
        core_msg_valid = '0;
        sys_rst_n      = 1'b1;
        #2 sys_rst_n   = 1'b0;
        #1;
        chk("rst_ready", core_msg_ready, 16'h0000);
        chk("rst_bv",    bc_msg_valid,   1'b0);
        chk("rst_bm",    bc_msg,         '0);
        chk("rst_rr",    dut.r_rr_ptr,   4'd15);
        step();
        step();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        step();
        chk("first_ready", core_msg_ready, 16'hFFFF);
        chk("first_bv",    bc_msg_valid,   1'b0);

        for (int k = 0; k < 8; k++) begin
            core_msg_valid = tbl[k].vin;
            alt_mask       = tbl[k].alt;
            step();
            chk($sformatf("tbl%0d_ready", k), core_msg_ready, tbl[k].exp_rdy);
            chk($sformatf("tbl%0d_bv", k),    bc_msg_valid,   tbl[k].exp_bv);
            chk($sformatf("tbl%0d_bm", k),    bc_msg,         tbl[k].exp_bm);
            if (k == 3) chk("rr_after_contention", dut.r_rr_ptr, 4'd9);
        end
        alt_mask = '0;

        // Fairness: rr_ptr is 3 after the table, so rotation starts at core 4.
        for (int i = 0; i < c_N; i++) cnt[i] = 0;
        pulses = 0; cyc = 0; exp_src = 4; rot_err = 0; first_cyc = 0; last_cyc = 0;
        core_msg_valid = '1;
        while (pulses < 64 && cyc < 100) begin
            step();
            cyc++;
            if (bc_msg_valid) begin
                src = src_of(bc_msg);
                if (src != exp_src) rot_err++;
                if (src >= 0) cnt[src]++;
                if (pulses == 0) first_cyc = cyc;
                last_cyc = cyc;
                pulses++;
                exp_src = (exp_src + 1) % c_N;
            end
        end
        chk("fair_pulses", pulses, 64);
        chk("fair_rotation_errors", rot_err, 0);
        chk("fair_span", last_cyc - first_cyc, 63);
        for (int i = 0; i < c_N; i++) chk($sformatf("fair_cnt%0d", i), cnt[i], 4);
        core_msg_valid = '0;
        for (int j = 0; j < 20; j++) step();
        chk("drain_ready", core_msg_ready, 16'hFFFF);
        chk("drain_bv",    bc_msg_valid,   1'b0);

        // Streaming from core 0: accept on even edges, broadcast on odd.
        acc = 0; pulses = 0; pat_err = 0;
        core_msg_valid = 16'h0001;
        for (int j = 0; j < 20; j++) begin
            if (core_msg_ready[0]) acc++;
            step();
            if (bc_msg_valid !== 1'((j % 2) == 1)) pat_err++;
            if (bc_msg_valid) begin
                pulses++;
                if (bc_msg !== msg_of(0)) pat_err++;
            end
        end
        core_msg_valid = '0;
        for (int j = 0; j < 3; j++) begin
            step();
            if (bc_msg_valid) pulses++;
        end
        chk("stream_accepts", acc, 10);
        chk("stream_pulses",  pulses, 10);
        chk("stream_pattern_errors", pat_err, 0);

        // Reset mid-operation with four entries pending.
        core_msg_valid = 16'h0055;
        step();
        chk("pre_rst_ready", core_msg_ready, 16'hFFAA);
        core_msg_valid = '0;
        #2 sys_rst_n = 1'b0;
        #1;
        chk("midrst_ready", core_msg_ready, 16'h0000);
        chk("midrst_bv",    bc_msg_valid,   1'b0);
        step();
        step();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        step();
        chk("postrst_ready", core_msg_ready, 16'hFFFF);
        chk("postrst_bv",    bc_msg_valid,   1'b0);
        stale = 0;
        for (int j = 0; j < 3; j++) begin
            step();
            if (bc_msg_valid) stale++;
        end
        chk("postrst_stale", stale, 0);
        alt_mask       = 16'h0004;
        core_msg_valid = 16'h0004;
        step();
        core_msg_valid = '0;
        step();
        chk("postrst_core2_bv", bc_msg_valid, 1'b1);
        chk("postrst_core2_bm", bc_msg,       alt_of(2));
        alt_mask = '0;
        step();

`ifdef BC_MSG_ARB_STATS_EN
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        step();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        step();
        core_msg_valid = 16'h0222;
        step();
        core_msg_valid = '0;
        for (int j = 0; j < 5; j++) step();
        chk("stats_count",    bc_msg_count,          32'd3);
        chk("stats_conflict", bc_msg_conflict_count, 32'd2);
        force dut.r_bc_msg_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_bc_msg_count;
        core_msg_valid = 16'h0001;
        step();
        core_msg_valid = '0;
        step();
        step();
        chk("stats_wrap", bc_msg_count, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
